// File: rtl/upsample_nn.sv
// 2x nearest-neighbour upsampler for channel-interleaved pixel streams.
// Each input row (STRING_LEN/2 pixels of CHANNEL_NUM words) is stored in one
// of two ping-pong line buffers and then replayed twice. In each replay every
// pixel is emitted twice, so one input row becomes two output rows.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   valid_i, data_i      input word, accepted when valid_i && ready_o
//   sop_i/eop_i          input row framing
//   sof_i/eof_i          input frame framing
//   ready_o              write buffer available
//   data_o, data_valid_o registered output word, no backpressure
//   sop_o/eop_o          output row framing (both copies)
//   sof_o/eof_o          output frame framing
//   err_o                sticky framing error
module upsample_nn #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned CHANNEL_NUM = 3,
  parameter int unsigned STRING_LEN  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         sop_i,
  input  logic                         eop_i,
  input  logic                         sof_i,
  input  logic                         eof_i,
  output logic                         ready_o,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         data_valid_o,
  output logic                         sop_o,
  output logic                         eop_o,
  output logic                         sof_o,
  output logic                         eof_o,
  output logic                         err_o
);

  localparam int unsigned IN_W  = (STRING_LEN / 2) * CHANNEL_NUM;
  localparam int unsigned OUT_W = STRING_LEN * CHANNEL_NUM;
  localparam int unsigned CW    = $clog2(OUT_W) + 1;
  localparam int unsigned AW    = $clog2(2 * IN_W);
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [CW-1:0] IN_LAST  = CW'(IN_W - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(OUT_W - 1);

  typedef enum logic [1:0] {StIdle, StEmit0, StEmit1} state_t;

  // Both line buffers share one array: buffer b occupies [b*IN_W +: IN_W].
  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]    full, buf_sof, buf_eof;
  logic          wb, rb;
  logic [CW-1:0] wcnt, rcnt;
  state_t        state;
  // Buffer release is deferred one cycle so it lines up with the last output word.
  logic          rel_pend, rel_buf;

  logic          accept;
  logic [CW-1:0] widx;
  logic [AW-1:0] waddr, raddr;
  logic          iss_en, iss_second, iss_last;
  logic [CW-1:0] iss_k;
  int unsigned   k_int, a_int;

  assign ready_o = !reset && !full[wb];
  assign accept  = valid_i && ready_o;
  // sop_i always restarts the row at index 0, even mid-row.
  assign widx    = sop_i ? '0 : wcnt;
  assign waddr   = AW'(widx) + (wb ? AW'(IN_W) : AW'(0));

  // Word issued to the RAM this cycle. IDLE already issues k=0 so the first
  // output appears two cycles after the committing eop.
  always_comb begin
    iss_en     = 1'b0;
    iss_second = 1'b0;
    iss_k      = rcnt;
    unique case (state)
      StIdle: begin
        iss_en = full[rb];
        iss_k  = '0;
      end
      StEmit0: iss_en = 1'b1;
      StEmit1: begin
        iss_en     = 1'b1;
        iss_second = 1'b1;
      end
      default: ;
    endcase
    iss_last = (iss_k == OUT_LAST);
    k_int    = 32'(iss_k);
    a_int    = ((k_int / CHANNEL_NUM) >> 1) * CHANNEL_NUM + (k_int % CHANNEL_NUM)
             + (rb ? IN_W : 32'd0);
    raddr    = AW'(a_int);
  end

  always_ff @(posedge clk) begin
    if (accept) mem[waddr] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full         <= '0;
      buf_sof      <= '0;
      buf_eof      <= '0;
      wb           <= 1'b0;
      rb           <= 1'b0;
      wcnt         <= '0;
      rcnt         <= '0;
      state        <= StIdle;
      rel_pend     <= 1'b0;
      rel_buf      <= 1'b0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      sop_o        <= 1'b0;
      eop_o        <= 1'b0;
      sof_o        <= 1'b0;
      eof_o        <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      // Release and commit always target different buffers, so both apply.
      rel_pend <= 1'b0;
      if (rel_pend) full[rel_buf] <= 1'b0;

      if (accept) begin
        if (sop_i && wcnt != '0) err_o <= 1'b1;
        if (widx == '0) begin
          buf_sof[wb] <= sof_i;
          buf_eof[wb] <= eof_i;
        end else begin
          buf_sof[wb] <= buf_sof[wb] | sof_i;
          buf_eof[wb] <= buf_eof[wb] | eof_i;
        end
        if (widx == IN_LAST) begin
          wcnt <= '0;
          if (eop_i) begin
            full[wb] <= 1'b1;
            wb       <= ~wb;
          end else begin
            err_o <= 1'b1;
          end
        end else if (eop_i) begin
          err_o <= 1'b1;
          wcnt  <= '0;
        end else begin
          wcnt <= widx + CW'(1);
        end
      end

      data_valid_o <= iss_en;
      data_o       <= iss_en ? mem[raddr] : '0;
      sop_o        <= iss_en && (iss_k == '0);
      eop_o        <= iss_en && iss_last;
      sof_o        <= iss_en && !iss_second && (iss_k == '0) && buf_sof[rb];
      eof_o        <= iss_en && iss_second && iss_last && buf_eof[rb];

      unique case (state)
        StIdle: begin
          if (full[rb]) begin
            state <= StEmit0;
            rcnt  <= CW'(1);
          end
        end
        StEmit0: begin
          if (rcnt == OUT_LAST) begin
            state <= StEmit1;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt + CW'(1);
          end
        end
        StEmit1: begin
          if (rcnt == OUT_LAST) begin
            rel_pend <= 1'b1;
            rel_buf  <= rb;
            rb       <= ~rb;
            rcnt     <= '0;
            state    <= full[~rb] ? StEmit0 : StIdle;
          end else begin
            rcnt <= rcnt + CW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
